// File: rtl/uart_receive.sv
// UART receiver (8 data bits, LSB first, idle-high line, configurable stop bits).
// Synchronises rx_in, samples each bit mid-period and holds the byte behind a valid/ack handshake.
module uart_receive #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned STOP_BITS    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0]       STOP_LAST = 2'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  logic             rx_meta;
  logic             rx_s;
  logic             rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [1:0]       stop_idx;
  logic             stop_bad;
  logic [7:0]       shift;

  // Synchroniser, edge history, receive FSM and holding register
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      cnt       <= '0;
      bit_idx   <= '0;
      stop_idx  <= '0;
      stop_bad  <= 1'b0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_meta   <= rx_in;
      rx_s      <= rx_meta;
      rx_prev   <= rx_s;
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // Consumer ack; a good completion in the same cycle overrides below
      if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          // Only a genuine falling edge starts a frame, never a held-low line
          if (rx_prev && !rx_s) begin
            state   <= START;
            cnt     <= '0;
            rx_busy <= 1'b1;
          end
        end

        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (rx_s) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state    <= STOP;
              stop_idx <= '0;
              stop_bad <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt      <= '0;
            stop_bad <= stop_bad | ~rx_s;
            stop_idx <= stop_idx + 2'd1;
            if (stop_idx == STOP_LAST) begin
              // Leave mid-stop-bit so a start edge at the next boundary is caught
              state   <= IDLE;
              rx_busy <= 1'b0;
              if (stop_bad || !rx_s) begin
                frame_err <= 1'b1;
              end else if (!rx_valid || rx_ack) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// Bench for uart_receive: directed scenarios plus random 8N2 frames checked
// against a frame-level handshake model.
module tb_uart_receive;

  localparam int unsigned CPB = 104;
  localparam int unsigned SB  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  // Frame-level reference model
  logic       exp_valid = 1'b0;
  logic [7:0] exp_data  = 8'h00;
  int         exp_ferr  = 0;
  int         exp_ovr   = 0;

  // Observed pulse statistics
  int   ferr_cnt  = 0;
  int   ovr_cnt   = 0;
  int   both_cnt  = 0;
  int   wide_cnt  = 0;
  logic ferr_q    = 1'b0;
  logic ovr_q     = 1'b0;

  uart_receive #(
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (SB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_in    (rx_in),
    .rx_ack   (rx_ack),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_busy  (rx_busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (frame_err && overrun) both_cnt++;
    if ((frame_err && ferr_q) || (overrun && ovr_q)) wide_cnt++;
    ferr_q = frame_err;
    ovr_q  = overrun;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx_in = v;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic s0, input logic s1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(s0);
    drive_bit(s1);
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    if (exp_valid) exp_valid = 1'b0;
    tick(1);
    rx_ack = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic s0, input logic s1);
    if (!s0 || !s1) exp_ferr++;
    else if (!exp_valid) begin
      exp_valid = 1'b1;
      exp_data  = b;
    end else exp_ovr++;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".valid"}, 32'(rx_valid), 32'(exp_valid));
    check({tag, ".data"},  32'(rx_data),  32'(exp_data));
    check({tag, ".ferr"},  32'(ferr_cnt), 32'(exp_ferr));
    check({tag, ".ovr"},   32'(ovr_cnt),  32'(exp_ovr));
    check({tag, ".busy"},  32'(rx_busy),  32'd0);
  endtask

  task automatic frame(input logic [7:0] b, input logic s0, input logic s1,
                       input logic ack, input string tag);
    if (ack) begin
      fork
        do_ack();
        send_frame(b, s0, s1);
      join
    end else begin
      send_frame(b, s0, s1);
    end
    model_frame(b, s0, s1);
    check_state(tag);
  endtask

  initial begin
    logic [7:0] b;
    logic       s0, s1, ack, need_gap;

    reset  = 1'b1;
    rx_in  = 1'b1;
    rx_ack = 1'b0;
    tick(5);
    check("rst.valid", 32'(rx_valid), 32'd0);
    check("rst.data",  32'(rx_data),  32'd0);
    check("rst.busy",  32'(rx_busy),  32'd0);
    check("rst.ferr",  32'(frame_err), 32'd0);
    check("rst.ovr",   32'(overrun),  32'd0);
    reset = 1'b0;
    tick(5);

    // Plain byte, then ack clears valid and keeps the data
    frame(8'hA5, 1'b1, 1'b1, 1'b0, "t1");
    do_ack();
    check_state("t1ack");

    // Short low pulse: aborts at the START sample
    rx_in = 1'b0;
    tick(10);
    check("glitch.busy_hi", 32'(rx_busy), 32'd1);
    tick(20);
    rx_in = 1'b1;
    tick(100);
    check_state("glitch");

    // Bad first stop bit
    frame(8'h3C, 1'b0, 1'b1, 1'b0, "t3");
    drive_bit(1'b1);

    // Overrun: second byte lands while the first is unacked
    frame(8'h11, 1'b1, 1'b1, 1'b0, "t4a");
    frame(8'h22, 1'b1, 1'b1, 1'b0, "t4b");

    // Reset in the middle of data bit 4
    b = 8'h96;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx_in = b[4];
    tick(CPB / 2);
    reset = 1'b1;
    rx_in = 1'b1;
    tick(3);
    check("t5.valid", 32'(rx_valid), 32'd0);
    check("t5.data",  32'(rx_data),  32'd0);
    check("t5.busy",  32'(rx_busy),  32'd0);
    check("t5.ferr",  32'(frame_err), 32'd0);
    check("t5.ovr",   32'(overrun),  32'd0);
    reset     = 1'b0;
    exp_valid = 1'b0;
    exp_data  = 8'h00;
    tick(2 * CPB);
    frame(8'h5A, 1'b1, 1'b1, 1'b0, "t5rx");

    // Back-to-back frames, each acked
    frame(8'h00, 1'b1, 1'b1, 1'b1, "t6a");
    frame(8'hFF, 1'b1, 1'b1, 1'b1, "t6b");
    do_ack();
    check_state("t6ack");

    // Random frames, acks, stop-bit errors and idle gaps
    need_gap = 1'b0;
    for (int n = 0; n < 14; n++) begin
      b   = 8'($urandom);
      s0  = 1'b1;
      s1  = 1'b1;
      if ($urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 1) == 0) s0 = 1'b0;
        else s1 = 1'b0;
      end
      ack = 1'($urandom_range(0, 1));
      if (need_gap) drive_bit(1'b1);
      repeat ($urandom_range(0, 2)) drive_bit(1'b1);
      frame(b, s0, s1, ack, $sformatf("rnd%0d", n));
      need_gap = !s1;
    end
    rx_in = 1'b1;
    tick(20);

    check("pulse.both", 32'(both_cnt), 32'd0);
    check("pulse.wide", 32'(wide_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
